// File: rtl/serial_terminal_rx.sv
// UART 8N1 receiver with 16x oversampling and a first-word-fall-through byte FIFO.
// rx_valid pulses one clock after the mid-stop-bit sample; the FIFO drops bytes when full (sticky overflow).
module serial_terminal_rx #(
   parameter int FIFO_DEPTH = 16,
   parameter int OVERSAMPLE = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          rx,
   input  logic [15:0]                   baud_div,
   input  logic                          rd_en,
   output logic [7:0]                    rd_data,
   output logic                          empty,
   output logic                          full,
   output logic [$clog2(FIFO_DEPTH):0]   level,
   output logic                          rx_valid,
   output logic [7:0]                    rx_byte,
   output logic                          frame_err,
   output logic                          overflow
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int OW = $clog2(OVERSAMPLE);
   localparam logic [OW-1:0] OS_MID  = OW'(OVERSAMPLE / 2 - 1);
   localparam logic [OW-1:0] OS_LAST = OW'(OVERSAMPLE - 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_START     = 3'd1,
      S_DATA      = 3'd2,
      S_STOP      = 3'd3,
      S_WAIT_IDLE = 3'd4
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;

   logic            r_sync1;
   logic            r_sync2;
   logic            w_rs;

   logic [15:0]     r_tick_cnt;
   logic            w_tick;
   logic [OW-1:0]   r_os_cnt;
   logic [2:0]      r_bit_idx;
   logic [7:0]      r_shift;

   logic            w_start_edge;
   logic            w_sample;
   logic            w_stop_pt;
   logic            w_accept;
   logic            w_ferr;

   logic            r_rx_valid;
   logic            r_frame_err;
   logic [7:0]      r_rx_byte;
   logic            r_overflow;

   logic [7:0]      r_mem [FIFO_DEPTH];
   logic [AW:0]     r_wr_ptr;
   logic [AW:0]     r_rd_ptr;
   logic            w_empty;
   logic            w_full;
   logic            w_push;
   logic            w_pop;

   // Two-flop synchronizer, preset high so reset never looks like a start bit
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= rx;
         r_sync2 <= r_sync1;
      end
   end

   assign w_rs   = r_sync2;
   assign w_tick = (r_tick_cnt == baud_div);

   // Restarting the divider on the start edge centres the samples in each bit
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tick_cnt <= 16'd0;
      end else if (w_start_edge || w_tick) begin
         r_tick_cnt <= 16'd0;
      end else begin
         r_tick_cnt <= r_tick_cnt + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (!w_rs) w_state_nxt = S_START;
         end
         S_START: begin
            if (w_tick && r_os_cnt == OS_MID) w_state_nxt = w_rs ? S_IDLE : S_DATA;
         end
         S_DATA: begin
            if (w_tick && r_os_cnt == OS_LAST && r_bit_idx == 3'd7) w_state_nxt = S_STOP;
         end
         S_STOP: begin
            if (w_tick && r_os_cnt == OS_LAST) w_state_nxt = w_rs ? S_IDLE : S_WAIT_IDLE;
         end
         S_WAIT_IDLE: begin
            if (w_rs) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_start_edge = 1'b0;
      w_sample     = 1'b0;
      w_stop_pt    = 1'b0;
      unique case (r_state)
         S_IDLE:  w_start_edge = !w_rs;
         S_DATA:  w_sample     = w_tick && (r_os_cnt == OS_LAST);
         S_STOP:  w_stop_pt    = w_tick && (r_os_cnt == OS_LAST);
         default: ;
      endcase
   end

   assign w_accept = w_stop_pt && w_rs;
   assign w_ferr   = w_stop_pt && !w_rs;

   // Oversample counter restarts on every state change, so each phase counts from zero
   always_ff @(posedge clk) begin
      if (rst) begin
         r_os_cnt <= '0;
      end else if (w_state_nxt != r_state) begin
         r_os_cnt <= '0;
      end else if (w_tick) begin
         r_os_cnt <= (r_os_cnt == OS_LAST) ? '0 : r_os_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_bit_idx <= 3'd0;
         r_shift   <= 8'h00;
      end else if (r_state == S_START) begin
         r_bit_idx <= 3'd0;
      end else if (w_sample) begin
         r_shift[r_bit_idx] <= w_rs;
         r_bit_idx          <= r_bit_idx + 3'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rx_valid  <= 1'b0;
         r_frame_err <= 1'b0;
         r_rx_byte   <= 8'h00;
         r_overflow  <= 1'b0;
      end else begin
         r_rx_valid  <= w_accept;
         r_frame_err <= w_ferr;
         if (w_accept) r_rx_byte <= r_shift;
         if (w_accept && w_full && !w_pop) r_overflow <= 1'b1;
      end
   end

   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_pop   = rd_en && !w_empty;
   // A pop in the same clock frees the slot, so a full FIFO still takes the byte
   assign w_push  = w_accept && (!w_full || w_pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= r_shift;
   end

   assign rd_data   = w_empty ? 8'h00 : r_mem[r_rd_ptr[AW-1:0]];
   assign empty     = w_empty;
   assign full      = w_full;
   assign level     = r_wr_ptr - r_rd_ptr;
   assign rx_valid  = r_rx_valid;
   assign rx_byte   = r_rx_byte;
   assign frame_err = r_frame_err;
   assign overflow  = r_overflow;

endmodule

// File: tb/tb_serial_terminal_rx.sv
// Directed bench for serial_terminal_rx: drives 8N1 frames at baud_div=3 and checks FIFO and flags.
module tb_serial_terminal_rx;

   logic        clk = 1'b0;
   logic        rst;
   logic        rx;
   logic [15:0] baud_div;
   logic        rd_en;
   logic [7:0]  rd_data;
   logic        empty;
   logic        full;
   logic [4:0]  level;
   logic        rx_valid;
   logic [7:0]  rx_byte;
   logic        frame_err;
   logic        overflow;

   int n_chk = 0;
   int n_bad = 0;
   int cyc = 0;
   int n_valid = 0;
   int n_ferr = 0;
   int last_valid_cyc = 0;
   int t_start = 0;
   int bit_clks = 64;
   int v0, f0;

   serial_terminal_rx #(.FIFO_DEPTH(16), .OVERSAMPLE(16)) dut (
      .clk(clk), .rst(rst), .rx(rx), .baud_div(baud_div), .rd_en(rd_en),
      .rd_data(rd_data), .empty(empty), .full(full), .level(level),
      .rx_valid(rx_valid), .rx_byte(rx_byte), .frame_err(frame_err), .overflow(overflow)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rx_valid) begin
         n_valid++;
         last_valid_cyc = cyc;
      end
      if (frame_err) n_ferr++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] d, input logic stop_b);
      rx = 1'b0;
      t_start = cyc;
      idle(bit_clks);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         idle(bit_clks);
      end
      rx = stop_b;
      idle(bit_clks);
   endtask

   task automatic pop_chk(input string tag, input logic [7:0] exp);
      chk(tag, rd_data, exp);
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; rx = 1'b1; rd_en = 1'b0; baud_div = 16'd3;
      idle(3);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_level", level, 0);
      chk("rst_rd_data", rd_data, 8'h00);
      chk("rst_rx_valid", rx_valid, 0);
      chk("rst_frame_err", frame_err, 0);
      chk("rst_rx_byte", rx_byte, 8'h00);
      chk("rst_overflow", overflow, 0);
      rst = 1'b0;
      idle(10);

      // 1: single byte and latency from start edge
      v0 = n_valid;
      send_byte(8'h55, 1'b1);
      idle(5);
      chk("t1_nvalid", n_valid - v0, 1);
      chk("t1_latency_in_range",
          ((last_valid_cyc - t_start) >= 606 && (last_valid_cyc - t_start) <= 614) ? 1 : 0, 1);
      chk("t1_rx_byte", rx_byte, 8'h55);
      chk("t1_level", level, 1);
      chk("t1_empty", empty, 0);
      pop_chk("t1_pop", 8'h55);
      chk("t1_empty_after", empty, 1);

      // 2: back-to-back frames
      v0 = n_valid;
      send_byte(8'h48, 1'b1);
      send_byte(8'h69, 1'b1);
      send_byte(8'h0A, 1'b1);
      idle(5);
      chk("t2_nvalid", n_valid - v0, 3);
      chk("t2_level", level, 3);
      pop_chk("t2_pop0", 8'h48);
      pop_chk("t2_pop1", 8'h69);
      pop_chk("t2_pop2", 8'h0A);
      chk("t2_empty", empty, 1);
      chk("t2_rd_data_empty", rd_data, 8'h00);

      // 3: short low glitch while idle
      v0 = n_valid; f0 = n_ferr;
      rx = 1'b0;
      idle(20);
      rx = 1'b1;
      idle(200);
      chk("t3_nvalid", n_valid - v0, 0);
      chk("t3_nferr", n_ferr - f0, 0);
      chk("t3_level", level, 0);

      // 4: bad stop bit followed by a long break, then recovery
      v0 = n_valid; f0 = n_ferr;
      send_byte(8'hA5, 1'b0);
      idle(2000);
      rx = 1'b1;
      idle(3 * bit_clks);
      chk("t4_nferr", n_ferr - f0, 1);
      chk("t4_nvalid", n_valid - v0, 0);
      chk("t4_level", level, 0);
      send_byte(8'h3C, 1'b1);
      idle(5);
      chk("t4_nvalid_after", n_valid - v0, 1);
      chk("t4_rx_byte", rx_byte, 8'h3C);
      pop_chk("t4_pop", 8'h3C);

      // 5: overflow after 16 unread bytes
      v0 = n_valid;
      chk("t5_overflow_before", overflow, 0);
      for (int i = 0; i < 17; i++) send_byte(8'(i), 1'b1);
      idle(5);
      chk("t5_nvalid", n_valid - v0, 17);
      chk("t5_full", full, 1);
      chk("t5_overflow", overflow, 1);
      chk("t5_level", level, 16);
      chk("t5_rx_byte", rx_byte, 8'h10);
      for (int i = 0; i < 16; i++) pop_chk($sformatf("t5_pop%0d", i), 8'(i));
      chk("t5_empty", empty, 1);
      chk("t5_overflow_sticky", overflow, 1);

      // 6: reset in the middle of a frame
      send_byte(8'h11, 1'b1);
      idle(5);
      chk("t6_level_pre", level, 1);
      rx = 1'b0;
      idle(3 * bit_clks);
      rst = 1'b1; rx = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("t6_rst_empty", empty, 1);
      chk("t6_rst_full", full, 0);
      chk("t6_rst_level", level, 0);
      chk("t6_rst_rd_data", rd_data, 8'h00);
      chk("t6_rst_rx_byte", rx_byte, 8'h00);
      chk("t6_rst_overflow", overflow, 0);
      chk("t6_rst_rx_valid", rx_valid, 0);
      chk("t6_rst_frame_err", frame_err, 0);
      v0 = n_valid; f0 = n_ferr;
      idle(2 * bit_clks);
      chk("t6_no_spurious", n_valid - v0, 0);
      send_byte(8'h7E, 1'b1);
      idle(5);
      chk("t6_nvalid", n_valid - v0, 1);
      chk("t6_nferr", n_ferr - f0, 0);
      chk("t6_rx_byte", rx_byte, 8'h7E);
      chk("t6_level", level, 1);
      pop_chk("t6_pop", 8'h7E);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/serial_terminal_rx.md
Name: serial_terminal_rx

Overview:
- Clocked UART 8N1 receiver that monitors the SoC UART_TX line and captures transmitted bytes into a small FIFO for the bench or debug logic to read.
- Replaces the behavioural terminal model with synthesizable RTL.
- Baud rate is set at run time by a 16-bit divisor.
- Reports framing errors and FIFO overflow.

Parameters:
- FIFO_DEPTH, 16, number of received-byte entries; power of two, minimum 2.
- OVERSAMPLE, 16, sample ticks per bit period; fixed at 16, not meant to be overridden.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- rx  input  1  serial line; idle high; asynchronous to clk.
- baud_div  input  16  tick divisor; one sample tick every baud_div+1 clocks.
- rd_en  input  1  pop the FIFO head; ignored when empty.
- rd_data  output  8  FIFO head byte, first-word fall-through; 0x00 when empty.
- empty  output  1  FIFO empty.
- full  output  1  FIFO full.
- level  output  $clog2(FIFO_DEPTH)+1  number of bytes held.
- rx_valid  output  1  one-clock pulse when a byte with a good stop bit is accepted.
- rx_byte  output  8  last accepted byte; holds its value until the next byte is accepted.
- frame_err  output  1  one-clock pulse on a bad stop bit.
- overflow  output  1  sticky; set when a good byte arrives while the FIFO is full; cleared only by rst.

Behaviour:
- Reset (sampled on the clk rising edge while rst=1):
  - FSM goes to IDLE; synchronizer flops are set to 1; tick counter is 0.
  - FIFO is emptied: empty=1, full=0, level=0, rd_data=0x00.
  - rx_valid=0, frame_err=0, rx_byte=0x00, overflow=0.
  - A reset asserted mid-frame aborts the frame and no byte is pushed.
- rx synchronization: 2-flop synchronizer; all decisions use the synchronized value rs.
- Tick generator:
  - Counter runs 0..baud_div; tick fires when the counter equals baud_div, then the counter wraps to 0.
  - Counter is forced to 0 on the IDLE->START transition so ticks are aligned to the start edge.
  - baud_div=0 gives a tick every clock.
  - Bit period = 16*(baud_div+1) clocks; baud_div=3 gives 64 clocks per bit.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: when rs=0, go to START and clear the tick count.
  - START: after 8 ticks (mid start bit), if rs=0 go to DATA with bit index 0; otherwise it was a glitch, return to IDLE, no flags.
  - DATA: every 16 ticks sample rs into shift bit[index], LSB first. After bit 7, go to STOP.
  - STOP: after 16 ticks (mid stop bit):
    - If rs=1: accept the byte. Pulse rx_valid next clock, update rx_byte, push into the FIFO, go to IDLE. Back-to-back frames must be received with no lost start bit.
    - If rs=0: pulse frame_err, discard the byte, go to WAIT_IDLE.
  - WAIT_IDLE: stay until rs=1, then go to IDLE (prevents a break condition from generating frames).
- FIFO:
  - Circular buffer with read/write pointers one bit wider than the address.
  - Push happens when a byte is accepted and the FIFO is not full.
  - Push while full drops the byte and sets overflow. rx_valid still pulses and rx_byte still updates.
  - Pop happens when rd_en=1 and empty=0; rd_data updates to the next entry the following clock.
  - Simultaneous push and pop: both occur and level is unchanged. This holds even when full: the pop frees the slot, the byte is stored, and overflow is not set.
  - Pointers wrap modulo FIFO_DEPTH.
- baud_div changes take effect at the next counter wrap; the bench changes it only in IDLE.

Test Plan:
1. baud_div=3; send 0x55 (64 clk/bit) -> rx_valid pulses once between 606 and 614 clocks after the start falling edge; rx_byte=0x55; level=1; rd_data=0x55; empty=0.
2. Send 0x48, 0x69, 0x0A back-to-back with no idle gap -> three rx_valid pulses. Pop with rd_en returns 0x48, 0x69, 0x0A in order, then empty=1 and rd_data=0x00.
3. Drive a 20-clock low glitch on rx while idle -> no rx_valid, no frame_err, level stays 0, FSM back in IDLE.
4. Send 0xA5 with the stop bit held low, then hold rx low for 2000 clocks before releasing -> one frame_err pulse, no push, no further frames; the next 0x3C is received correctly.
5. Send 17 bytes 0x00..0x10 without reading -> full=1 after 16 bytes, overflow=1, level=16; popping yields 0x00..0x0F.
6. Assert rst mid-byte (during DATA) for one clock -> all outputs return to their reset values; the following frame 0x7E is received correctly.
